// File: rtl/mul_div_sequencer.sv
// Iterative radix-2 multiply/divide unit with its controller FSM.
// Multiplies by LSB-first shift-add, divides by restoring division, both on operand magnitudes.
module mul_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] resultHi,
    output logic [WIDTH-1:0] resultLo,
    output logic             divByZero
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 res_sign_q, res_sign_d;
    logic                 rem_sign_q, rem_sign_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic [WIDTH-1:0]     result_lo_q, result_lo_d;
    logic                 div_by_zero_q, div_by_zero_d;

    logic                 is_div;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   neg_acc;
    logic [WIDTH-1:0]     neg_quo, neg_rem;

    // Signed ops are op[0]=1; the operation type is decided by op[1]
    assign is_div  = op_q[1];
    assign sign_a  = op_q[0] & opa_q[WIDTH-1];
    assign sign_b  = op_q[0] & opb_q[WIDTH-1];
    assign mag_a   = sign_a ? ('0 - opa_q) : opa_q;
    assign mag_b   = sign_b ? ('0 - opb_q) : opb_q;

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

    assign neg_acc = '0 - acc_q;
    assign neg_quo = '0 - acc_q[WIDTH-1:0];
    assign neg_rem = '0 - acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        res_sign_d    = res_sign_q;
        rem_sign_d    = rem_sign_q;
        result_hi_d   = result_hi_q;
        result_lo_d   = result_lo_q;
        div_by_zero_d = div_by_zero_q;

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = PREP;
                        op_d    = op;
                        opa_d   = opA;
                        opb_d   = opB;
                    end else begin
                        state_d = IDLE;
                    end
                end
                PREP: begin
                    if (is_div && opb_q == '0) begin
                        state_d       = DONE;
                        result_lo_d   = '1;
                        result_hi_d   = opa_q;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d    = ITER;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        res_sign_d = sign_a ^ sign_b;
                        rem_sign_d = sign_a & is_div;
                        opnd_d     = is_div ? mag_b : mag_a;
                        acc_d      = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
                    end
                end
                ITER: begin
                    if (is_div) begin
                        if (div_ge) begin
                            acc_d = {div_sub, acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = FIXUP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIXUP: begin
                    state_d       = DONE;
                    div_by_zero_d = 1'b0;
                    if (is_div) begin
                        result_lo_d = res_sign_q ? neg_quo : acc_q[WIDTH-1:0];
                        result_hi_d = rem_sign_q ? neg_rem : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        {result_hi_d, result_lo_d} = res_sign_q ? neg_acc : acc_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == PREP) || (state_d == ITER) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            res_sign_q    <= 1'b0;
            rem_sign_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_hi_q   <= '0;
            result_lo_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            res_sign_q    <= res_sign_d;
            rem_sign_q    <= rem_sign_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_hi_q   <= result_hi_d;
            result_lo_q   <= result_lo_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultHi  = result_hi_q;
    assign resultLo  = result_lo_q;
    assign divByZero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: a table of directed vectors plus
// hand-written sequences for flush, back-to-back starts and mid-operation reset.
module tb_mul_div_sequencer;

    localparam int WIDTH = 32;
    localparam logic [1:0] UMUL = 2'b00, SMUL = 2'b01, UDIV = 2'b10, SDIV = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA, opB;
    logic             flush;
    logic             busy, done, divByZero;
    logic [WIDTH-1:0] resultHi, resultLo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          exp_lat;
    } vec_t;

    vec_t vectors[13];

    mul_div_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .opA       (opA),
        .opB       (opB),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .resultHi  (resultHi),
        .resultLo  (resultLo),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One request: start pulses for a cycle, then done latency, busy span and results are checked
    task automatic applyStimulus(input string name, input logic [1:0] v_op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dbz, input int exp_lat);
        int cyc;
        int busy_cnt;
        start = 1'b1;
        op    = v_op;
        opA   = a;
        opB   = b;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 60) begin
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        checkOutput({name, " latency"}, 64'(cyc), 64'(exp_lat));
        checkOutput({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
        checkOutput({name, " busy_at_done"}, 64'(busy), 64'(0));
        checkOutput({name, " result"}, {resultHi, resultLo}, {exp_hi, exp_lo});
        checkOutput({name, " divByZero"}, 64'(divByZero), 64'(exp_dbz));
        tick();
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int first_done;
        vectors[0]  = '{UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35};
        vectors[1]  = '{SMUL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35};
        vectors[2]  = '{SMUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35};
        vectors[3]  = '{SDIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
        vectors[4]  = '{SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
        vectors[5]  = '{UDIV, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 35};
        vectors[6]  = '{UDIV, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 2};
        vectors[7]  = '{UMUL, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 35};
        vectors[8]  = '{SMUL, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 35};
        vectors[9]  = '{SDIV, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 35};
        vectors[10] = '{UMUL, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 35};
        vectors[11] = '{UDIV, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 35};
        vectors[12] = '{SDIV, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 2};

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opA   = '0;
        opB   = '0;
        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset result", {resultHi, resultLo}, 64'(0));
        checkOutput("reset divByZero", 64'(divByZero), 64'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            applyStimulus($sformatf("vec%0d", i), vectors[i].op, vectors[i].a, vectors[i].b,
                          vectors[i].exp_hi, vectors[i].exp_lo, vectors[i].exp_dbz, vectors[i].exp_lat);
        end

        // Flush in cycle 10 of a multiply: abort, no done, previous div-by-zero results kept
        start = 1'b1;
        op    = UMUL;
        opA   = 32'hFFFFFFFF;
        opB   = 32'h00000002;
        tick();
        start = 1'b0;
        for (cyc = 1; cyc < 10; cyc++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush busy_next", 64'(busy), 64'(0));
        checkOutput("flush done_next", 64'(done), 64'(0));
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        checkOutput("flush no_activity", 64'(done_cnt), 64'(0));
        checkOutput("flush result_kept", {resultHi, resultLo}, {32'hFFFFFFF8, 32'hFFFFFFFF});
        checkOutput("flush dbz_kept", 64'(divByZero), 64'(1));
        applyStimulus("after_flush", UMUL, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 35);

        // flush and start together: request dropped
        start = 1'b1;
        flush = 1'b1;
        op    = UDIV;
        opA   = 32'd9;
        opB   = 32'd0;
        tick();
        start = 1'b0;
        flush = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        checkOutput("flush_start dropped", 64'(done_cnt), 64'(0));
        checkOutput("flush_start result", {resultHi, resultLo}, {32'd0, 32'd42});

        // start held high throughout; operands changed while busy must not be resampled
        start = 1'b1;
        op    = UDIV;
        opA   = 32'd100;
        opB   = 32'd7;
        tick();
        op  = UMUL;
        opA = 32'd3;
        opB = 32'd5;
        cyc = 1;
        while (!done && cyc < 60) begin
            tick();
            cyc++;
        end
        checkOutput("b2b first_latency", 64'(cyc), 64'(35));
        checkOutput("b2b first_result", {resultHi, resultLo}, {32'd2, 32'd14});
        first_done = cyc;
        tick();
        cyc++;
        checkOutput("b2b done_drops", 64'(done), 64'(0));
        while (!done && cyc < 120) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        checkOutput("b2b gap", 64'(cyc - first_done), 64'(35));
        checkOutput("b2b second_result", {resultHi, resultLo}, {32'd0, 32'd15});
        tick();
        tick();

        // Asynchronous reset in the middle of ITER clears outputs without a clock edge
        start = 1'b1;
        op    = SMUL;
        opA   = 32'd11;
        opB   = 32'd13;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset busy", 64'(busy), 64'(0));
        checkOutput("midreset done", 64'(done), 64'(0));
        checkOutput("midreset result", {resultHi, resultLo}, 64'(0));
        checkOutput("midreset divByZero", 64'(divByZero), 64'(0));
        tick();
        reset = 1'b0;
        tick();
        applyStimulus("after_reset", SMUL, 32'd11, 32'hFFFFFFF3, 32'hFFFFFFFF, 32'hFFFFFF71, 1'b0, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
